// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // ceil(w * log10(2)); log10(2) is carried in units of 1e-5 to stay in integers.
  function automatic int unsigned min_digits(input int unsigned w);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 0; i < w; i++) begin
      acc += 30103;
    end
    return (acc + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus of the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;

  modport master (
    output start, bin,
    input  ready, busy, done, bcd, neg, ovf
  );

  modport slave (
    input  start, bin,
    output ready, busy, done, bcd, neg, ovf
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_DIGIT_W'(5)) begin
      d_o = d_i + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle double-dabble converter: one input bit per clock, start/done handshake,
// optional two's-complement input and a sticky overflow flag.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [BIN_W-1:0] sr_q;
  logic [BCD_W-1:0] acc_q;
  logic             ovf_acc_q;
  logic             sign_q;

  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [BCD_W-1:0] bcd_q;
  logic             neg_q;
  logic             ovf_q;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_d;
  logic [BIN_W-1:0] sr_d;
  logic             carry_out;
  logic             ovf_acc_d;
  logic             in_neg;
  logic [BIN_W-1:0] in_mag;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (acc_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is folded into the overflow accumulator.
  always_comb begin
    {carry_out, acc_d, sr_d} = {acc_adj, sr_q, 1'b0};
    ovf_acc_d = ovf_acc_q | carry_out;
  end

  always_comb begin
    in_neg = (SIGNED != 0) && bus.bin[BIN_W-1];
    in_mag = bus.bin;
    if (in_neg) begin
      in_mag = ~bus.bin + BIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      sign_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            sr_q      <= in_mag;
            sign_q    <= in_neg;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            bit_cnt_q <= CNT_W'(BIN_W - 1);
            state_q   <= SHIFT;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          acc_q     <= acc_d;
          sr_q      <= sr_d;
          ovf_acc_q <= ovf_acc_d;
          if (bit_cnt_q == '0) begin
            // Results come from the final shift directly so they are valid while done is high.
            state_q <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= acc_d;
            ovf_q   <= ovf_acc_d;
            neg_q   <= sign_q;
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three configurations (5-digit unsigned,
// 4-digit unsigned, 5-digit signed) against an arithmetic reference model.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if0 ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) if1 ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if2 ();

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic        st [3];
  logic [15:0] bn [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic        ng  [3];
  logic        ov  [3];
  logic [19:0] bc  [3];

  assign if0.start = st[0];
  assign if0.bin   = bn[0];
  assign if1.start = st[1];
  assign if1.bin   = bn[1];
  assign if2.start = st[2];
  assign if2.bin   = bn[2];

  assign rdy[0] = if0.ready;
  assign rdy[1] = if1.ready;
  assign rdy[2] = if2.ready;
  assign bsy[0] = if0.busy;
  assign bsy[1] = if1.busy;
  assign bsy[2] = if2.busy;
  assign dn[0]  = if0.done;
  assign dn[1]  = if1.done;
  assign dn[2]  = if2.done;
  assign ng[0]  = if0.neg;
  assign ng[1]  = if1.neg;
  assign ng[2]  = if2.neg;
  assign ov[0]  = if0.ovf;
  assign ov[1]  = if1.ovf;
  assign ov[2]  = if2.ovf;
  assign bc[0]  = if0.bcd;
  assign bc[1]  = {4'h0, if1.bcd};
  assign bc[2]  = if2.bcd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  d;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of the magnitude, computed with integer division.
  function automatic void model(input logic [1:0] d, input logic [15:0] b,
                                output logic [19:0] e, output logic n, output logic o);
    int     digits;
    longint mag;
    longint lim;
    longint r;
    digits = (d == 2'd1) ? 4 : 5;
    n   = (d == 2'd2) && b[15];
    mag = n ? (longint'(65536) - longint'(b)) : longint'(b);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    o = (mag >= lim);
    r = mag % lim;
    e = '0;
    for (int i = 0; i < digits; i++) begin
      e[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  // Starts one conversion and waits for done; optionally pulses start mid-conversion.
  task automatic do_conv(input logic [1:0] d, input logic [15:0] b, input int pulse_at);
    int lat;
    @(negedge clk);
    chk("ready_before_start", 32'(rdy[d]), 32'd1);
    st[d] = 1'b1;
    bn[d] = b;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    bn[d] = 16'($urandom);
    chk("busy_after_accept", {30'd0, bsy[d], rdy[d]}, 32'd2);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (dn[d]) break;
      if (lat == pulse_at) begin
        st[d] = 1'b1;
        bn[d] = 16'h1111;
      end else if (lat == pulse_at + 1) begin
        st[d] = 1'b0;
      end
    end
    chk("latency", 32'(lat), 32'd16);
    chk("ready_busy_in_done", {30'd0, rdy[d], bsy[d]}, 32'd2);
  endtask

  initial begin
    logic [19:0] e_bcd;
    logic        e_neg;
    logic        e_ovf;
    logic [15:0] rb;
    logic        seen;
    int          cnt;

    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      bn[i] = '0;
    end

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", 32'(rdy[i]), 32'd1);
      chk("reset_busy",  32'(bsy[i]), 32'd0);
      chk("reset_done",  32'(dn[i]),  32'd0);
      chk("reset_bcd",   32'(bc[i]),  32'd0);
      chk("reset_neg",   32'(ng[i]),  32'd0);
      chk("reset_ovf",   32'(ov[i]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    chk("min_digits_16", min_digits(16), 32'd5);
    chk("min_digits_4",  min_digits(4),  32'd2);
    chk("min_digits_2",  min_digits(2),  32'd1);
    chk("min_digits_32", min_digits(32), 32'd10);

    tbl.push_back('{2'd0, 16'd0,     20'h00000, 1'b0, 1'b0});
    tbl.push_back('{2'd0, 16'd65535, 20'h65535, 1'b0, 1'b0});
    tbl.push_back('{2'd0, 16'd1,     20'h00001, 1'b0, 1'b0});
    tbl.push_back('{2'd1, 16'd12345, 20'h02345, 1'b0, 1'b1});
    tbl.push_back('{2'd1, 16'd9999,  20'h09999, 1'b0, 1'b0});
    tbl.push_back('{2'd1, 16'd10000, 20'h00000, 1'b0, 1'b1});
    tbl.push_back('{2'd1, 16'd65535, 20'h05535, 1'b0, 1'b1});
    tbl.push_back('{2'd2, 16'h8000,  20'h32768, 1'b1, 1'b0});
    tbl.push_back('{2'd2, 16'hFFFF,  20'h00001, 1'b1, 1'b0});
    tbl.push_back('{2'd2, 16'h7FFF,  20'h32767, 1'b0, 1'b0});
    tbl.push_back('{2'd2, 16'h0000,  20'h00000, 1'b0, 1'b0});
    tbl.push_back('{2'd2, 16'hFF85,  20'h00123, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      do_conv(tbl[i].d, tbl[i].bin, (i == 1) ? 5 : -10);
      chk("tbl_bcd", 32'(bc[tbl[i].d]), 32'(tbl[i].bcd));
      chk("tbl_neg", 32'(ng[tbl[i].d]), 32'(tbl[i].neg));
      chk("tbl_ovf", 32'(ov[tbl[i].d]), 32'(tbl[i].ovf));
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(dn[tbl[i].d]), 32'd0);
      chk("bcd_holds",      32'(bc[tbl[i].d]), 32'(tbl[i].bcd));
      chk("ovf_holds",      32'(ov[tbl[i].d]), 32'(tbl[i].ovf));
    end

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        rb = 16'($urandom);
        model(2'(d), rb, e_bcd, e_neg, e_ovf);
        do_conv(2'(d), rb, -10);
        chk("rand_bcd", 32'(bc[d]), 32'(e_bcd));
        chk("rand_neg", 32'(ng[d]), 32'(e_neg));
        chk("rand_ovf", 32'(ov[d]), 32'(e_ovf));
      end
    end

    // Back-to-back conversions with start held high.
    @(negedge clk);
    st[0] = 1'b1;
    bn[0] = 16'd1234;
    @(posedge clk);
    #1;
    bn[0] = 16'd4321;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        @(posedge clk);
        cnt++;
        #1;
      end while (!dn[0] && cnt < 40);
      chk("b2b_period", 32'(cnt), 32'd16);
      chk("b2b_bcd", 32'(bc[0]), (k % 2 == 0) ? 32'h01234 : 32'h04321);
      if (k == 3) begin
        st[0] = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        chk("b2b_reaccepted", 32'(bsy[0]), 32'd1);
        bn[0] = (k % 2 == 0) ? 16'd1234 : 16'd4321;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle_ready", 32'(rdy[0]), 32'd1);

    // Reset in the middle of a conversion.
    do_conv(2'd0, 16'd777, -10);
    chk("pre_rst_bcd", 32'(bc[0]), 32'h00777);
    @(negedge clk);
    st[0] = 1'b1;
    bn[0] = 16'd999;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(rdy[0]), 32'd1);
    chk("midrst_busy",  32'(bsy[0]), 32'd0);
    chk("midrst_done",  32'(dn[0]),  32'd0);
    chk("midrst_bcd",   32'(bc[0]),  32'd0);
    chk("midrst_ovf",   32'(ov[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (dn[0]) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    do_conv(2'd0, 16'd42, -10);
    chk("post_rst_bcd", 32'(bc[0]), 32'h00042);
    chk("post_rst_ovf", 32'(ov[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
